// File: rtl/config_loader_if.sv
// Stream and scan-chain pin bundle between a configuration source and config_loader.
// master: the side that issues start/abort and supplies words.
// slave:  the loader itself, which drives the chain pins and status.
interface config_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  start;
  logic                  abort;
  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_valid;
  logic                  word_ready;
  logic                  config_out;
  logic                  config_enable;
  logic                  config_nreset;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, word_in, word_valid,
    input  word_ready, config_out, config_enable, config_nreset, busy, done
  );

  modport slave (
    input  start, abort, word_in, word_valid,
    output word_ready, config_out, config_enable, config_nreset, busy, done
  );
endinterface

// File: rtl/config_loader.sv
// Feeds a LogicColumn configuration scan chain: optional clear pulse, then
// LSB-first serialisation of incoming words, one bit per clock, until the
// chain length has been shifted.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start, chain pins quiet
// ST_CLEAR | config_nreset held low, down-counter times the clear
// ST_LOAD  | accepting words and shifting bits onto config_out
// ST_DONE  | whole chain shifted, done held until the next start
module config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_BITS   = 1024,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic           clock,
  input  logic           reset,
  config_loader_if.slave bus
);

  localparam int BCW = $clog2(CHAIN_BITS + 1);
  localparam int SCW = $clog2(WORD_WIDTH + 1);
  localparam int CCW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  // shreg holds the bits of the current word not yet presented; shcnt counts them
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [SCW-1:0]        shcnt_q, shcnt_d;
  logic [BCW-1:0]        bit_count_q, bit_count_d;
  logic [CCW-1:0]        clr_cnt_q, clr_cnt_d;
  logic                  config_out_q, config_out_d;
  logic                  config_enable_q, config_enable_d;
  logic                  config_nreset_q, config_nreset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  word_ready;
  logic                  accept;
  int                    remaining;
  int                    take;

  // Ready only when nothing is left to shift and the chain still has room;
  // the last bit of a word is already sitting in config_out, so this keeps
  // the stream gap-free at one word per WORD_WIDTH cycles.
  assign word_ready = (state_q == ST_LOAD) && (shcnt_q == '0) &&
                      (bit_count_q != BCW'(CHAIN_BITS));
  assign accept     = word_ready && bus.word_valid;

  // Next-state, shifter and output computation
  always_comb begin
    state_d         = state_q;
    shreg_d         = shreg_q;
    shcnt_d         = shcnt_q;
    bit_count_d     = bit_count_q;
    clr_cnt_d       = clr_cnt_q;
    config_out_d    = config_out_q;
    config_enable_d = 1'b0;
    config_nreset_d = 1'b1;
    done_d          = done_q;
    // a final partial word only contributes the bits the chain still needs
    remaining       = CHAIN_BITS - int'(bit_count_q);
    take            = (remaining < WORD_WIDTH) ? remaining : WORD_WIDTH;

    if (bus.abort) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      shcnt_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d         = ST_CLEAR;
            done_d          = 1'b0;
            bit_count_d     = '0;
            clr_cnt_d       = CCW'(CLEAR_CYCLES - 1);
            config_nreset_d = 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == '0) begin
            state_d = ST_LOAD;
          end else begin
            clr_cnt_d       = clr_cnt_q - 1'b1;
            config_nreset_d = 1'b0;
          end
        end
        ST_LOAD: begin
          if (bit_count_q == BCW'(CHAIN_BITS)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (shcnt_q != '0) begin
            config_out_d    = shreg_q[0];
            config_enable_d = 1'b1;
            shreg_d         = shreg_q >> 1;
            shcnt_d         = shcnt_q - 1'b1;
            bit_count_d     = bit_count_q + 1'b1;
          end else if (accept) begin
            config_out_d    = bus.word_in[0];
            config_enable_d = 1'b1;
            shreg_d         = bus.word_in >> 1;
            shcnt_d         = SCW'(take - 1);
            bit_count_d     = bit_count_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_CLEAR) || (state_d == ST_LOAD);
  end

  // State and registered outputs, all cleared by the asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      shreg_q         <= '0;
      shcnt_q         <= '0;
      bit_count_q     <= '0;
      clr_cnt_q       <= '0;
      config_out_q    <= 1'b0;
      config_enable_q <= 1'b0;
      config_nreset_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      shreg_q         <= shreg_d;
      shcnt_q         <= shcnt_d;
      bit_count_q     <= bit_count_d;
      clr_cnt_q       <= clr_cnt_d;
      config_out_q    <= config_out_d;
      config_enable_q <= config_enable_d;
      config_nreset_q <= config_nreset_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign bus.word_ready    = word_ready;
  assign bus.config_out    = config_out_q;
  assign bus.config_enable = config_enable_q;
  assign bus.config_nreset = config_nreset_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader with WORD_WIDTH=8, CHAIN_BITS=20, CLEAR_CYCLES=2.
// The reference model is a bit queue: an accepted word pushes the bits the
// chain still needs, and exactly one bit must leave per cycle from the next
// cycle on, with config_enable low whenever the queue is empty.
module tb_config_loader;

  localparam int W  = 8;
  localparam int CB = 20;

  typedef struct {
    logic [7:0]  w0;
    logic [7:0]  w1;
    logic [7:0]  w2;
    int          gap;
    logic [19:0] exp_stream;
  } vec_t;

  logic clock;
  logic reset;
  config_loader_if #(.WORD_WIDTH(W)) bus ();

  config_loader #(.WORD_WIDTH(W), .CHAIN_BITS(CB), .CLEAR_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   exp_q[$];
  int   pushed, accepted, cap_n, first_cyc, last_cyc, cur_run, max_run;
  int   cyc = 0;
  bit   done_pending;
  logic [19:0] cap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pushed = 0; accepted = 0; cap_n = 0; cap = '0;
    first_cyc = 0; last_cyc = 0; cur_run = 0; max_run = 0;
    done_pending = 0;
  endtask

  // Reference model and stream monitor, sampled mid-cycle
  always @(negedge clock) begin
    int  n;
    bit  b;
    cyc++;
    if (mon_en) begin
      if (done_pending) begin
        chk("done_after_last_bit", bus.done, 1);
        chk("ready_after_done", bus.word_ready, 0);
        chk("busy_after_done", bus.busy, 0);
        done_pending = 0;
      end
      if (bus.config_enable) cur_run++; else cur_run = 0;
      if (cur_run > max_run) max_run = cur_run;
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("enable_on_bit", bus.config_enable, 1);
        chk("serial_bit", bus.config_out, b);
        if (cap_n == 0) first_cyc = cyc;
        last_cyc = cyc;
        if (cap_n < CB) cap[cap_n] = bus.config_out;
        cap_n++;
        if (cap_n == CB) done_pending = 1;
      end else begin
        chk("enable_idle", bus.config_enable, 0);
      end
      if (pushed >= CB) chk("ready_when_full", bus.word_ready, 0);
      if (bus.word_valid && bus.word_ready && !bus.abort) begin
        n = (CB - pushed < W) ? CB - pushed : W;
        for (int k = 0; k < n; k++) exp_q.push_back(bus.word_in[k]);
        pushed += n;
        accepted++;
      end
      if (bus.abort) begin
        exp_q.delete();
        done_pending = 0;
      end
    end
  end

  // Offer a word; gap>0 first leaves valid low for that many ready cycles
  task automatic send_word(input logic [7:0] w, input int gap, output bit ok);
    int t;
    if (gap > 0) begin
      bus.word_valid = 1'b0;
      t = 0;
      do begin @(negedge clock); t++; end while (!bus.word_ready && t < 60);
      repeat (gap - 1) @(negedge clock);
      @(posedge clock); #1;
    end
    bus.word_in    = w;
    bus.word_valid = 1'b1;
    ok = 0;
    t  = 0;
    while (t < 60) begin
      @(negedge clock);
      if (bus.word_ready) begin ok = 1; break; end
      t++;
    end
    @(posedge clock); #1;
  endtask

  task automatic do_start();
    model_reset();
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_bits(input int nbits);
    int t = 0;
    while (cap_n < nbits && t < 100) begin @(negedge clock); #1; t++; end
    chk("wait_bits_reached", (cap_n >= nbits), 1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!bus.done && t < 200) begin @(negedge clock); t++; end
    chk("done_set", bus.done, 1);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    do_start();
    send_word(v.w0, 0, ok);     chk("accept_w0", ok, 1);
    send_word(v.w1, v.gap, ok); chk("accept_w1", ok, 1);
    send_word(v.w2, v.gap, ok); chk("accept_w2", ok, 1);
    bus.word_in = 8'h77;
    wait_done();
    repeat (4) begin @(posedge clock); #1; end
    bus.word_valid = 1'b0;
    chk("stream", cap, v.exp_stream);
    chk("words_accepted", accepted, 3);
    chk("enable_span", last_cyc - first_cyc + 1, CB + 2 * v.gap);
    chk("max_enable_run", max_run, (v.gap == 0) ? CB : W);
  endtask

  initial begin
    vec_t vecs[4];
    vec_t rv;
    int   lowcnt, t;
    bit   ok;

    vecs[0] = '{w0: 8'hA5, w1: 8'h3C, w2: 8'h0F, gap: 0, exp_stream: 20'hF3CA5};
    vecs[1] = '{w0: 8'hA5, w1: 8'h3C, w2: 8'h0F, gap: 3, exp_stream: 20'hF3CA5};
    vecs[2] = '{w0: 8'hFF, w1: 8'h00, w2: 8'hFA, gap: 0, exp_stream: 20'hA00FF};
    vecs[3] = '{w0: 8'h01, w1: 8'h80, w2: 8'hF5, gap: 1, exp_stream: 20'h58001};

    bus.start = 0; bus.abort = 0; bus.word_in = '0; bus.word_valid = 0;
    model_reset();
    reset = 1'b1;
    #1;
    chk("rst_config_out", bus.config_out, 0);
    chk("rst_config_enable", bus.config_enable, 0);
    chk("rst_config_nreset", bus.config_nreset, 0);
    chk("rst_word_ready", bus.word_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    #12 reset = 1'b0;
    @(posedge clock); #1;
    chk("nreset_after_release", bus.config_nreset, 1);
    chk("busy_after_release", bus.busy, 0);
    mon_en = 1;

    // clear pulse length and first ready
    do_start();
    chk("start_busy", bus.busy, 1);
    chk("clear_ready_low", bus.word_ready, 0);
    lowcnt = 0; t = 0;
    while (!bus.config_nreset && t < 10) begin
      lowcnt++; t++;
      @(posedge clock); #1;
    end
    chk("clear_cycles", lowcnt, 2);
    chk("ready_after_clear", bus.word_ready, 1);
    chk("busy_in_load", bus.busy, 1);
    bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.abort = 1'b0;
    chk("abort_idle_busy", bus.busy, 0);

    // table of full loads, back-to-back and with valid gaps
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // abort after 10 bits, then a fresh full load
    do_start();
    send_word(8'hA5, 0, ok);
    send_word(8'h3C, 0, ok);
    bus.word_valid = 1'b0;
    wait_bits(9);
    @(posedge clock); #1;
    bus.abort = 1'b1;
    @(posedge clock); #1;
    bus.abort = 1'b0;
    chk("abort_bits_shifted", cap_n, 10);
    chk("abort_enable", bus.config_enable, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_nreset", bus.config_nreset, 1);
    repeat (3) begin @(posedge clock); #1; end
    run_vec(vecs[0]);

    // start during LOAD is ignored, then reset lands mid-stream
    do_start();
    send_word(8'hA5, 0, ok);
    bus.word_valid = 1'b0;
    wait_bits(2);
    @(posedge clock); #1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    chk("start_in_load_nreset", bus.config_nreset, 1);
    chk("start_in_load_busy", bus.busy, 1);
    wait_bits(5);
    #2;
    mon_en = 0;
    reset  = 1'b1;
    #1;
    chk("midrst_enable", bus.config_enable, 0);
    chk("midrst_nreset", bus.config_nreset, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_ready", bus.word_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_done", bus.done, 0);
    chk("post_rst_nreset", bus.config_nreset, 1);
    model_reset();
    mon_en = 1;

    // randomized loads against the queue model
    for (int r = 0; r < 8; r++) begin
      rv.w0  = 8'($urandom);
      rv.w1  = 8'($urandom);
      rv.w2  = 8'($urandom);
      rv.gap = int'($urandom_range(0, 3));
      rv.exp_stream = {rv.w2[3:0], rv.w1, rv.w0};
      run_vec(rv);
    end

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
